// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_multicycle_ctrl                                               |
// | Desc   : Multi-cycle MIPS control FSM with memory-ready stall and retire    |
// |          counter.                                                          |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl #(
  parameter bit WAIT_MEM = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ExtZero,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InsCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPE  = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_XORI  = 6'b001110;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;
  localparam logic [5:0] C_FN_JR    = 6'b001000;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       ext_zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctrl_t;

  // Strobes that depend only on the state (and on Op, which is stable from DECODE on)
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
      S_DECODE: c.alu_src_b = 2'd3;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'd1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_RTYPE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 2'd1; end
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'd1; end
      S_IEXEC, S_IWB: begin
        c.alu_op    = (op == C_OP_ADDI) ? 2'b00 : 2'b11;
        c.ext_zero  = (op == C_OP_ANDI) || (op == C_OP_ORI) || (op == C_OP_XORI);
        c.reg_write = (s == S_IWB);
        c.alu_src_a = (s == S_IEXEC);
        c.alu_src_b = (s == S_IEXEC) ? 2'd2 : 2'd0;
      end
      S_JUMP:   begin c.pc_src = 2'd2; c.pc_en = 1'b1; end
      S_JAL:    begin
        c.pc_src = 2'd2; c.pc_en = 1'b1; c.reg_write = 1'b1;
        c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
      end
      S_JR:     begin c.alu_src_a = 1'b1; c.pc_src = 2'd3; c.pc_en = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   ins_count_q, ins_count_d;
  logic               ready;
  logic               retire;
  logic               illegal;

  always_comb begin
    ready   = MemReady | ~WAIT_MEM;
    state_d = state_q;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          C_OP_RTYPE:            state_d = (Funct == C_FN_JR) ? S_JR : S_RTYPE;
          C_OP_LW, C_OP_SW:      state_d = S_MEMADR;
          C_OP_BEQ, C_OP_BNE:    state_d = S_BRANCH;
          C_OP_ADDI, C_OP_ANDI, C_OP_ORI,
          C_OP_XORI, C_OP_SLTI:  state_d = S_IEXEC;
          C_OP_J:                state_d = S_JUMP;
          C_OP_JAL:              state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_RTYPE:  state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JAL, S_JR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    ins_count_d = retire ? ins_count_q + CNT_W'(1) : ins_count_q;
    ctrl_d      = decode_ctrl(state_d, Op);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_FETCH;
      ins_count_q <= '0;
      ctrl_q      <= decode_ctrl(S_FETCH, Op);
    end else begin
      state_q     <= state_d;
      ins_count_q <= ins_count_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // Handshake- and flag-qualified strobes cannot be registered ahead of time
  assign IRWrite   = (state_q == S_FETCH) & ready;
  assign PCEn      = ctrl_q.pc_en
                   | ((state_q == S_FETCH) & ready)
                   | ((state_q == S_BRANCH) & (Zero ^ (Op == C_OP_BNE)));
  assign IllegalOp = illegal;

  assign IorD      = ctrl_q.iord;
  assign MemRead   = ctrl_q.mem_read;
  assign MemWrite  = ctrl_q.mem_write;
  assign RegWrite  = ctrl_q.reg_write;
  assign RegDst    = ctrl_q.reg_dst;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign ExtZero   = ctrl_q.ext_zero;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign PCSrc     = ctrl_q.pc_src;
  assign State     = state_q;
  assign InsCount  = ins_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mips_multicycle_ctrl                                            |
// | Desc   : Directed vector bench for the multi-cycle MIPS control FSM.        |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_mips_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST, Zero, MemReady;
  logic [5:0]  Op, Funct;
  logic        IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtZero, ALUSrcA, PCEn, IllegalOp;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  State;
  logic [31:0] InsCount;

  // Second instance: narrow counter, memory handshake ignored
  logic        rst2, zero2, ready2;
  logic [5:0]  op2, funct2;
  logic        iord2, mr2, mw2, irw2, rw2, ext2, srca2, pcen2, ill2;
  logic [1:0]  rdst2, m2r2, srcb2, aluop2, pcsrc2;
  logic [3:0]  state2;
  logic [2:0]  cnt2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.WAIT_MEM(1'b1), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtZero(ExtZero),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .State(State), .InsCount(InsCount)
  );

  mips_multicycle_ctrl #(.WAIT_MEM(1'b0), .CNT_W(3)) u_wrap (
    .CLK(CLK), .RST(rst2), .Op(op2), .Funct(funct2), .Zero(zero2), .MemReady(ready2),
    .IorD(iord2), .MemRead(mr2), .MemWrite(mw2), .IRWrite(irw2),
    .RegWrite(rw2), .RegDst(rdst2), .MemtoReg(m2r2), .ExtZero(ext2),
    .ALUSrcA(srca2), .ALUSrcB(srcb2), .ALUOp(aluop2), .PCSrc(pcsrc2), .PCEn(pcen2),
    .IllegalOp(ill2), .State(state2), .InsCount(cnt2)
  );

  logic [18:0] dut_out;
  assign dut_out = {IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                    ExtZero, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp};

  // Expected strobes for a state, transcribed from the state table
  function automatic logic [18:0] exp_out(input logic [3:0] s, input logic [5:0] op,
                                          input logic z, input logic rdy);
    logic iord, mr, mw, irw, rw, ext, srca, pcen, ill;
    logic [1:0] rdst, m2r, srcb, aluop, pcsrc;
    logic legal;
    {iord, mr, mw, irw, rw, ext, srca, pcen, ill} = '0;
    {rdst, m2r, srcb, aluop, pcsrc} = '0;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001000) ||
            (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110) ||
            (op == 6'b001010) || (op == 6'b000010) || (op == 6'b000011);
    case (s)
      4'd0:  begin mr = 1; srcb = 2'd1; irw = rdy; pcen = rdy; end
      4'd1:  begin srcb = 2'd3; ill = ~legal; end
      4'd2:  begin srca = 1; srcb = 2'd2; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; rdst = 2'd0; m2r = 2'd1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin srca = 1; aluop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 2'd1; end
      4'd8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'd1;
                   pcen = (op == 6'b000100) ? z : ~z; end
      4'd9:  begin srca = 1; srcb = 2'd2; end
      4'd10: rw = 1;
      4'd11: begin pcsrc = 2'd2; pcen = 1; end
      4'd12: begin pcsrc = 2'd2; pcen = 1; rw = 1; rdst = 2'd2; m2r = 2'd2; end
      4'd13: begin srca = 1; pcsrc = 2'd3; pcen = 1; end
      default: ;
    endcase
    if (s == 4'd9 || s == 4'd10) begin
      aluop = (op == 6'b001000) ? 2'b00 : 2'b11;
      ext   = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
    end
    return {iord, mr, mw, irw, rw, rdst, m2r, ext, srca, srcb, aluop, pcsrc, pcen, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [31:0] seq;   // nibble c = state in cycle c
    logic [7:0]  rdy;   // bit c = MemReady in cycle c
    logic        retire;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int len, input logic [31:0] seq,
                              input logic [7:0] rdy, input logic ret);
    vec_t v;
    v.name = name; v.op = op; v.funct = fn; v.zero = z; v.len = len;
    v.seq = seq; v.rdy = rdy; v.retire = ret;
    return v;
  endfunction

  // Entered and left one time unit after a rising edge with the DUT in FETCH
  task automatic run(input vec_t v);
    logic [3:0] s;
    Op = v.op; Funct = v.funct; Zero = v.zero;
    for (int c = 0; c < v.len; c++) begin
      MemReady = v.rdy[c];
      s = v.seq[c*4 +: 4];
      @(negedge CLK);
      check({v.name, " state"}, {28'd0, State}, {28'd0, s});
      check({v.name, " outs"}, {13'd0, dut_out}, {13'd0, exp_out(s, v.op, v.zero, MemReady)});
      @(posedge CLK); #1;
    end
    if (v.retire) exp_cnt = exp_cnt + 32'd1;
    check({v.name, " end state"}, {28'd0, State}, 32'd0);
    check({v.name, " count"}, InsCount, exp_cnt);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk("lw",      6'b100011, 6'd0,      1'b0, 5, 32'h0004_3210, 8'hFF, 1'b1));
    tbl.push_back(mk("sw",      6'b101011, 6'd0,      1'b0, 4, 32'h0000_5210, 8'hFF, 1'b1));
    tbl.push_back(mk("add",     6'b000000, 6'b100000, 1'b0, 4, 32'h0000_7610, 8'hFF, 1'b1));
    tbl.push_back(mk("jr",      6'b000000, 6'b001000, 1'b0, 3, 32'h0000_0D10, 8'hFF, 1'b1));
    tbl.push_back(mk("beq z1",  6'b000100, 6'd0,      1'b1, 3, 32'h0000_0810, 8'hFF, 1'b1));
    tbl.push_back(mk("beq z0",  6'b000100, 6'd0,      1'b0, 3, 32'h0000_0810, 8'hFF, 1'b1));
    tbl.push_back(mk("bne z1",  6'b000101, 6'd0,      1'b1, 3, 32'h0000_0810, 8'hFF, 1'b1));
    tbl.push_back(mk("bne z0",  6'b000101, 6'd0,      1'b0, 3, 32'h0000_0810, 8'hFF, 1'b1));
    tbl.push_back(mk("addi",    6'b001000, 6'b001000, 1'b0, 4, 32'h0000_A910, 8'hFF, 1'b1));
    tbl.push_back(mk("ori",     6'b001101, 6'd0,      1'b0, 4, 32'h0000_A910, 8'hFF, 1'b1));
    tbl.push_back(mk("andi",    6'b001100, 6'd0,      1'b0, 4, 32'h0000_A910, 8'hFF, 1'b1));
    tbl.push_back(mk("xori",    6'b001110, 6'd0,      1'b0, 4, 32'h0000_A910, 8'hFF, 1'b1));
    tbl.push_back(mk("slti",    6'b001010, 6'd0,      1'b0, 4, 32'h0000_A910, 8'hFF, 1'b1));
    tbl.push_back(mk("j",       6'b000010, 6'd0,      1'b0, 3, 32'h0000_0B10, 8'hFF, 1'b1));
    tbl.push_back(mk("jal",     6'b000011, 6'd0,      1'b0, 3, 32'h0000_0C10, 8'hFF, 1'b1));
    tbl.push_back(mk("illegal", 6'b111111, 6'd0,      1'b0, 2, 32'h0000_0010, 8'hFF, 1'b0));

    RST = 1'b0; MemReady = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    rst2 = 1'b0; op2 = 6'b000010; funct2 = '0; zero2 = 1'b0; ready2 = 1'b0;
    exp_cnt = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("reset state", {28'd0, State}, 32'd0);
    check("reset count", InsCount, 32'd0);
    check("reset outs", {13'd0, dut_out}, {13'd0, exp_out(4'd0, Op, Zero, MemReady)});
    RST = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    run(mk("sw wait",    6'b101011, 6'd0,      1'b0, 7, 32'h0555_5210, 8'h47, 1'b1));
    run(mk("fetch wait", 6'b000000, 6'b100100, 1'b0, 6, 32'h0076_1000, 8'h3C, 1'b1));
    run(mk("lw wait",    6'b100011, 6'd0,      1'b0, 6, 32'h0043_3210, 8'h37, 1'b1));

    // Reset while stalled in MEMRD
    Op = 6'b100011; MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    MemReady = 1'b0;
    @(negedge CLK);
    check("pre-reset memrd", {28'd0, State}, 32'd3);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      check("rst state", {28'd0, State}, 32'd0);
      check("rst count", InsCount, 32'd0);
      check("rst regwrite", {31'd0, RegWrite}, 32'd0);
      check("rst memread", {31'd0, MemRead}, 32'd1);
    end
    RST = 1'b1; MemReady = 1'b1; exp_cnt = '0;
    run(tbl[13]);

    // Narrow counter wraps back to zero; MemReady is ignored there
    rst2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      repeat (3) @(posedge CLK);
      #1;
      check("wrap state", {28'd0, state2}, 32'd0);
      check("wrap count", {29'd0, cnt2}, 32'(k % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
